// File: rtl/pipeline_stall_control.sv
// Pipeline advance/stall controller driven by the debug unit's run/step requests.
// Produces the latch enables, flush and bubble controls, and two saturating counters.
module pipeline_stall_control #(
  parameter int unsigned CANT_BITS_CONTADOR = 32
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable_ejecucion,
  input  logic                          i_step,
  input  logic                          i_bit_burbuja,
  input  logic                          i_branch_taken,
  input  logic                          i_halt_wb,
  output logic                          o_enable_pc,
  output logic                          o_enable_if_id,
  output logic                          o_flush_if_id,
  output logic                          o_nop_id_ex,
  output logic                          o_enable_etapas,
  output logic                          o_halted,
  output logic [CANT_BITS_CONTADOR-1:0] o_contador_ciclos,
  output logic [CANT_BITS_CONTADOR-1:0] o_contador_burbujas
);

  typedef enum logic [1:0] {StEspera, StRun, StStep, StHalt} state_e;

  localparam logic [CANT_BITS_CONTADOR-1:0] CntMax = {CANT_BITS_CONTADOR{1'b1}};
  localparam logic [CANT_BITS_CONTADOR-1:0] CntOne = {{(CANT_BITS_CONTADOR-1){1'b0}}, 1'b1};

  state_e                          state_q, state_d;
  logic [CANT_BITS_CONTADOR-1:0]   ciclos_q, ciclos_d;
  logic [CANT_BITS_CONTADOR-1:0]   burbujas_q, burbujas_d;
  logic                            advance;

  // Reset is gated in so a reset cycle never advances the pipeline or counts.
  assign advance = i_reset && ((state_q == StRun) || (state_q == StStep));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= StEspera;
      ciclos_q   <= '0;
      burbujas_q <= '0;
    end else begin
      state_q    <= state_d;
      ciclos_q   <= ciclos_d;
      burbujas_q <= burbujas_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEspera: begin
        if (i_enable_ejecucion) begin
          state_d = StRun;
        end else if (i_step) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (i_halt_wb) begin
          state_d = StHalt;
        end else if (!i_enable_ejecucion) begin
          state_d = StEspera;
        end
      end
      StStep: begin
        state_d = i_halt_wb ? StHalt : StEspera;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StEspera;
      end
    endcase
  end

  always_comb begin
    o_enable_pc     = 1'b0;
    o_enable_if_id  = 1'b0;
    o_flush_if_id   = 1'b0;
    o_nop_id_ex     = 1'b0;
    o_enable_etapas = 1'b0;
    if (advance) begin
      o_enable_etapas = 1'b1;
      if (i_bit_burbuja) begin
        // Load-use stall dominates a taken branch; the branch re-resolves next cycle.
        o_nop_id_ex = 1'b1;
      end else begin
        o_enable_pc    = 1'b1;
        o_enable_if_id = 1'b1;
        o_flush_if_id  = i_branch_taken;
      end
    end
    o_halted = (state_q == StHalt);
  end

  always_comb begin
    ciclos_d   = ciclos_q;
    burbujas_d = burbujas_q;
    if (advance && (ciclos_q != CntMax)) begin
      ciclos_d = ciclos_q + CntOne;
    end
    if (advance && i_bit_burbuja && (burbujas_q != CntMax)) begin
      burbujas_d = burbujas_q + CntOne;
    end
  end

  assign o_contador_ciclos   = ciclos_q;
  assign o_contador_burbujas = burbujas_q;

endmodule

// File: tb/tb_pipeline_stall_control.sv
// Bench for pipeline_stall_control: directed vector table, saturation sequence on a
// 4-bit instance, and randomized traffic against a rule-level reference model.
module tb_pipeline_stall_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, step, burb, br, halt;
  logic pc, ifid, fl, nop, et, hl;
  logic [31:0] cyc, bub;
  logic s_pc, s_ifid, s_fl, s_nop, s_et, s_hl;
  logic [3:0] s_cyc, s_bub;

  pipeline_stall_control dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable_ejecucion(en), .i_step(step),
    .i_bit_burbuja(burb), .i_branch_taken(br), .i_halt_wb(halt),
    .o_enable_pc(pc), .o_enable_if_id(ifid), .o_flush_if_id(fl), .o_nop_id_ex(nop),
    .o_enable_etapas(et), .o_halted(hl), .o_contador_ciclos(cyc), .o_contador_burbujas(bub)
  );

  pipeline_stall_control #(.CANT_BITS_CONTADOR(4)) dut_s (
    .i_clock(clk), .i_reset(rst_n), .i_enable_ejecucion(en), .i_step(step),
    .i_bit_burbuja(burb), .i_branch_taken(br), .i_halt_wb(halt),
    .o_enable_pc(s_pc), .o_enable_if_id(s_ifid), .o_flush_if_id(s_fl), .o_nop_id_ex(s_nop),
    .o_enable_etapas(s_et), .o_halted(s_hl), .o_contador_ciclos(s_cyc),
    .o_contador_burbujas(s_bub)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=waiting, 1=running, 2=single step, 3=halted.
  int mode = 0;
  longint m_cyc = 0;
  longint m_bub = 0;

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic bit m_adv();
    return rst_n && (mode == 1 || mode == 2);
  endfunction

  task automatic model_step();
    bit a;
    a = m_adv();
    if (!rst_n) begin
      mode = 0; m_cyc = 0; m_bub = 0;
    end else begin
      if (a) m_cyc++;
      if (a && burb) m_bub++;
      case (mode)
        0: mode = en ? 1 : (step ? 2 : 0);
        1: mode = halt ? 3 : (en ? 1 : 0);
        2: mode = halt ? 3 : 0;
        default: mode = 3;
      endcase
    end
  endtask

  task automatic model_check();
    bit a;
    a = m_adv();
    chk("enable_pc", {31'b0, pc}, {31'b0, a && !burb});
    chk("enable_if_id", {31'b0, ifid}, {31'b0, a && !burb});
    chk("flush_if_id", {31'b0, fl}, {31'b0, a && !burb && br});
    chk("nop_id_ex", {31'b0, nop}, {31'b0, a && burb});
    chk("enable_etapas", {31'b0, et}, {31'b0, a});
    chk("halted", {31'b0, hl}, {31'b0, mode == 3});
    chk("ciclos", cyc, 32'(sat(m_cyc, 64'hFFFF_FFFF)));
    chk("burbujas", bub, 32'(sat(m_bub, 64'hFFFF_FFFF)));
    chk("ciclos_4b", {28'b0, s_cyc}, 32'(sat(m_cyc, 15)));
    chk("burbujas_4b", {28'b0, s_bub}, 32'(sat(m_bub, 15)));
  endtask

  task automatic drive(input bit r, input bit e, input bit s, input bit b, input bit j,
                       input bit h);
    rst_n = r; en = e; step = s; burb = b; br = j; halt = h;
  endtask

  // One cycle: inputs are already driven just after a rising edge.
  task automatic tick(input bit do_check);
    @(negedge clk);
    if (do_check) model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    bit r, e, s, b, j, h;
    bit pc, ifid, fl, nop, et, hl;
    int cyc, bub;
  } vec_t;

  vec_t vt[26];

  initial begin
    //        r e s b j h   pc if fl np et hl  cyc bub
    vt[0]  = '{0,0,0,0,0,0, 0,0,0,0,0,0, 0,0};
    vt[1]  = '{1,1,0,0,0,0, 0,0,0,0,0,0, 0,0};
    vt[2]  = '{1,1,0,0,0,0, 1,1,0,0,1,0, 0,0};
    vt[3]  = '{1,1,0,0,0,0, 1,1,0,0,1,0, 1,0};
    vt[4]  = '{1,1,0,0,0,0, 1,1,0,0,1,0, 2,0};
    vt[5]  = '{1,1,0,0,0,0, 1,1,0,0,1,0, 3,0};
    vt[6]  = '{1,0,0,0,0,0, 1,1,0,0,1,0, 4,0};
    vt[7]  = '{1,0,0,0,0,0, 0,0,0,0,0,0, 5,0};
    vt[8]  = '{1,0,1,0,0,0, 0,0,0,0,0,0, 5,0};
    vt[9]  = '{1,0,0,0,0,0, 1,1,0,0,1,0, 5,0};
    vt[10] = '{1,0,0,0,0,0, 0,0,0,0,0,0, 6,0};
    vt[11] = '{1,0,1,0,0,0, 0,0,0,0,0,0, 6,0};
    vt[12] = '{1,0,0,0,0,0, 1,1,0,0,1,0, 6,0};
    vt[13] = '{1,0,0,0,0,0, 0,0,0,0,0,0, 7,0};
    vt[14] = '{1,0,1,0,0,0, 0,0,0,0,0,0, 7,0};
    vt[15] = '{1,0,0,0,0,0, 1,1,0,0,1,0, 7,0};
    vt[16] = '{1,0,0,0,0,0, 0,0,0,0,0,0, 8,0};
    vt[17] = '{1,1,0,0,0,0, 0,0,0,0,0,0, 8,0};
    vt[18] = '{1,1,0,1,0,0, 0,0,0,1,1,0, 8,0};
    vt[19] = '{1,1,0,1,1,0, 0,0,0,1,1,0, 9,1};
    vt[20] = '{1,1,0,0,1,0, 1,1,1,0,1,0, 10,2};
    vt[21] = '{1,1,0,0,0,1, 1,1,0,0,1,0, 11,2};
    vt[22] = '{1,1,1,0,0,0, 0,0,0,0,0,1, 12,2};
    vt[23] = '{1,1,0,1,1,0, 0,0,0,0,0,1, 12,2};
    vt[24] = '{0,1,0,0,0,0, 0,0,0,0,0,1, 12,2};
    vt[25] = '{1,0,0,0,0,0, 0,0,0,0,0,0, 0,0};

    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); model_step(); #1;
    @(posedge clk); model_step(); #1;

    for (int i = 0; i < 26; i++) begin
      drive(vt[i].r, vt[i].e, vt[i].s, vt[i].b, vt[i].j, vt[i].h);
      @(negedge clk);
      chk($sformatf("vec%0d_pc", i), {31'b0, pc}, {31'b0, vt[i].pc});
      chk($sformatf("vec%0d_ifid", i), {31'b0, ifid}, {31'b0, vt[i].ifid});
      chk($sformatf("vec%0d_flush", i), {31'b0, fl}, {31'b0, vt[i].fl});
      chk($sformatf("vec%0d_nop", i), {31'b0, nop}, {31'b0, vt[i].nop});
      chk($sformatf("vec%0d_etapas", i), {31'b0, et}, {31'b0, vt[i].et});
      chk($sformatf("vec%0d_halted", i), {31'b0, hl}, {31'b0, vt[i].hl});
      chk($sformatf("vec%0d_ciclos", i), cyc, vt[i].cyc);
      chk($sformatf("vec%0d_burbujas", i), bub, vt[i].bub);
      @(posedge clk);
      model_step();
      #1;
    end

    // Saturation on the 4-bit instance: 19 advance cycles must stop at 15.
    drive(0, 0, 0, 0, 0, 0);
    tick(1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, (i % 3) == 0, 0, 0);
      tick(1);
    end
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat_ciclos_4b", {28'b0, s_cyc}, 32'd15);
    chk("sat_ciclos_32b", cyc, 32'd19);
    @(posedge clk); model_step(); #1;

    // Randomized traffic, with occasional resets to escape halt.
    drive(0, 0, 0, 0, 0, 0);
    tick(1);
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) >= 3,
            $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 4);
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_control.md
PIPELINE_STALL_CONTROL -- requirements
Module: pipeline_stall_control

Interface
REQ-001 Parameter CANT_BITS_CONTADOR, default 32, width of both performance counters.
REQ-002 i_clock  input  1  single clock; all state updates on rising edge.
REQ-003 i_reset  input  1  reset, synchronous, active-low.
REQ-004 i_enable_ejecucion  input  1  continuous-run request from debug unit (level).
REQ-005 i_step  input  1  single-step request from debug unit (one-cycle pulse).
REQ-006 i_bit_burbuja  input  1  load-use bubble request from hazard detection unit.
REQ-007 i_branch_taken  input  1  branch/jump resolved taken in ID.
REQ-008 i_halt_wb  input  1  halt instruction present in WB stage.
REQ-009 o_enable_pc  output  1  PC write enable.
REQ-010 o_enable_if_id  output  1  IF/ID latch write enable.
REQ-011 o_flush_if_id  output  1  IF/ID latch loads NOP.
REQ-012 o_nop_id_ex  output  1  ID/EX latch loads NOP (control bits zeroed).
REQ-013 o_enable_etapas  output  1  write enable for ID/EX, EX/MEM, MEM/WB latches.
REQ-014 o_halted  output  1  pipeline halted, high only in state HALT.
REQ-015 o_contador_ciclos  output  CANT_BITS_CONTADOR  advance cycles since reset.
REQ-016 o_contador_burbujas  output  CANT_BITS_CONTADOR  bubbles inserted since reset.

Function
REQ-017 FSM SHALL have states ESPERA, RUN, STEP, HALT, one-hot or binary encoding at implementer's choice.
REQ-018 ESPERA: i_enable_ejecucion=1 -> RUN; else i_step=1 -> STEP; else stay (run request wins over simultaneous step).
REQ-019 RUN: i_halt_wb=1 -> HALT; else i_enable_ejecucion=0 -> ESPERA; else stay.
REQ-020 STEP: i_halt_wb=1 -> HALT; else -> ESPERA unconditionally (exactly one advance cycle per step pulse).
REQ-021 HALT: terminal; left only by reset; i_step and i_enable_ejecucion ignored.
REQ-022 Advance cycle defined as current state RUN or STEP; control outputs SHALL be combinational from current state and same-cycle inputs (zero latency).
REQ-023 Non-advance cycle: o_enable_pc, o_enable_if_id, o_enable_etapas, o_flush_if_id, o_nop_id_ex all 0; i_bit_burbuja and i_branch_taken ignored.
REQ-024 Advance, no hazard: o_enable_pc=1, o_enable_if_id=1, o_enable_etapas=1, flush=0, nop=0.
REQ-025 Advance with i_bit_burbuja=1: o_enable_pc=0, o_enable_if_id=0, o_nop_id_ex=1, o_enable_etapas=1, o_flush_if_id=0.
REQ-026 Advance with i_branch_taken=1 and i_bit_burbuja=0: o_enable_pc=1, o_enable_if_id=1, o_flush_if_id=1, o_enable_etapas=1, nop=0.
REQ-027 Both i_bit_burbuja and i_branch_taken high: bubble rule (REQ-025) wins; no flush that cycle.
REQ-028 Cycle with i_halt_wb=1 in RUN/STEP is still an advance cycle (outputs per REQ-024..027, counters update); HALT from next cycle.
REQ-029 o_contador_ciclos SHALL increment by 1 on every advance cycle; saturate at all-ones (no wrap).
REQ-030 o_contador_burbujas SHALL increment by 1 on every advance cycle with i_bit_burbuja=1; saturate at all-ones.
REQ-031 Counters registered; value visible the cycle after the counted cycle.

Reset
REQ-032 i_reset=0 sampled at rising edge SHALL force state ESPERA, both counters 0, o_halted 0, from any state including mid-RUN and HALT.
REQ-033 During and right after reset all enables, flush and nop outputs SHALL be 0 until a run/step request is accepted.
REQ-034 Reset has priority over every other input in the same cycle.

Verification
REQ-035 Reset, then i_enable_ejecucion=1 for 5 cycles -> cycle 1 ESPERA (enables 0), next 4 cycles enables 1; o_contador_ciclos=4.
REQ-036 In ESPERA pulse i_step once, 3 times with gaps -> exactly 3 advance cycles, o_contador_ciclos=3, enables low between steps.
REQ-037 RUN with i_bit_burbuja=1 for 1 cycle -> that cycle o_enable_pc=0, o_enable_if_id=0, o_nop_id_ex=1; o_contador_burbujas=1.
REQ-038 RUN with i_bit_burbuja=1 and i_branch_taken=1 together -> stall outputs, o_flush_if_id=0; next cycle branch alone -> o_flush_if_id=1, o_enable_pc=1.
REQ-039 RUN, i_halt_wb=1 one cycle -> that cycle enables 1, next cycle o_halted=1 and enables 0; further i_step/i_enable ignored; i_reset=0 returns to ESPERA with counters 0.
REQ-040 Counters preloaded near max via parameter CANT_BITS_CONTADOR=4, run 20 cycles -> o_contador_ciclos holds 15, no wrap.
